jtframe_mr_ddrarb: RTL and testbench

Parametrised, burst-aware arbiter that shares the MiSTer DDR Avalon-MM port among CH masters, such as the ROM downloader, the rotation frame buffer and core-side DDR users. It supersedes the fixed two-way mux. A grant is held for the full burst, so no transfer is ever split or corrupted when ownership changes. The block sits between the jtframe DDR clients and the HPS DDR bridge.

---
 rtl/jtframe_mr_ddrarb_pkg.sv | 24 ++
 rtl/jtframe_ddrarb_pick.sv | 39 +++
 rtl/jtframe_mr_ddrarb.sv | 148 ++++++++++++++
 tb/tb_jtframe_mr_ddrarb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mr_ddrarb_pkg.sv
// Shared definitions for the burst-aware DDR arbiter: FSM encoding and burst helpers.
package jtframe_mr_ddrarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_t;

    // Widest burst-count field the helpers below accept
    localparam int unsigned BCNT_MAXW = 32;

    // Byte-enable width for a given data width
    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // Effective burst length: a zero burst count means a single beat
    function automatic logic [BCNT_MAXW-1:0] burst_len(input logic [BCNT_MAXW-1:0] bcnt);
        return (bcnt == '0) ? BCNT_MAXW'(1) : bcnt;
    endfunction

endpackage

// File: rtl/jtframe_ddrarb_pick.sv
// Combinational winner selection for the DDR arbiter.
// JTFRAME_MR_DDRARB_RR_EN selects round-robin search starting at ptr;
// otherwise the lowest requesting index wins.
module jtframe_ddrarb_pick #(
    parameter int unsigned CH = 2,
    parameter int unsigned IW = 1
) (
    input  logic [CH-1:0] req,
`ifdef JTFRAME_MR_DDRARB_RR_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [CH-1:0] onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First requester found in search order wins
    always_comb begin
        int unsigned c;
        c      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
`ifdef JTFRAME_MR_DDRARB_RR_EN
            c = 32'(ptr) + k;
            if (c >= CH) c = c - CH;
`else
            c = k;
`endif
            if (!any && req[c]) begin
                any       = 1'b1;
                idx       = IW'(c);
                onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_mr_ddrarb.sv
// Burst-aware arbiter sharing the MiSTer DDR Avalon-MM port among CH masters.
// A grant is held until the whole burst has transferred.
// JTFRAME_MR_DDRARB_RR_EN enables round-robin; default is fixed priority (channel 0 highest).
module jtframe_mr_ddrarb
    import jtframe_mr_ddrarb_pkg::*;
#(
    parameter int unsigned CH = 2,
    parameter int unsigned AW = 29,
    parameter int unsigned DW = 64,
    parameter int unsigned BW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       m_rd,
    input  logic [CH-1:0]       m_we,
    input  logic [CH*AW-1:0]    m_addr,
    input  logic [CH*BW-1:0]    m_burstcnt,
    input  logic [CH*DW-1:0]    m_din,
    input  logic [CH*DW/8-1:0]  m_be,
    output logic [CH-1:0]       m_busy,
    output logic [CH-1:0]       m_dout_ready,
    output logic [DW-1:0]       m_dout,
    output logic [CH-1:0]       grant,
    output logic                ddr_clk,
    input  logic                ddr_busy,
    output logic                ddr_rd,
    output logic                ddr_we,
    output logic [AW-1:0]       ddr_addr,
    output logic [BW-1:0]       ddr_burstcnt,
    output logic [DW-1:0]       ddr_din,
    output logic [DW/8-1:0]     ddr_be,
    input  logic [DW-1:0]       ddr_dout,
    input  logic                ddr_dout_ready
);

    localparam int unsigned BEW = be_width(DW);
    localparam int unsigned IW  = (CH > 1) ? $clog2(CH) : 1;

    arb_state_t     state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  sel_c;
    logic [IW-1:0]  pick_idx_c;
    logic [CH-1:0]  req_c;
    logic [CH-1:0]  pick_oh_c;
    logic           pick_any_c;
    logic [BW-1:0]  cnt;
    logic [BW-1:0]  len_c;
    logic           rd_acc_c;
    logic           wr_acc_c;
    logic           done_c;
`ifdef JTFRAME_MR_DDRARB_RR_EN
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  next_ptr_c;
`endif

    assign req_c = m_rd | m_we;

    jtframe_ddrarb_pick #(
        .CH (CH),
        .IW (IW)
    ) u_pick (
        .req    (req_c),
`ifdef JTFRAME_MR_DDRARB_RR_EN
        .ptr    (ptr),
`endif
        .onehot (pick_oh_c),
        .idx    (pick_idx_c),
        .any    (pick_any_c)
    );

    // Channel 0 drives the DDR payload while idle so the bus stays deterministic
    assign sel_c = (state == ST_IDLE) ? '0 : idx;

    // DDR-side payload mux and command gating
    always_comb begin
        ddr_addr     = m_addr[sel_c*AW +: AW];
        ddr_burstcnt = m_burstcnt[sel_c*BW +: BW];
        ddr_din      = m_din[sel_c*DW +: DW];
        ddr_be       = m_be[sel_c*BEW +: BEW];
        ddr_rd       = (state == ST_CMD) & m_rd[sel_c];
        ddr_we       = ((state == ST_CMD) | (state == ST_WDATA)) & m_we[sel_c];
        len_c        = BW'(burst_len(BCNT_MAXW'(ddr_burstcnt)));
    end

    assign rd_acc_c = ddr_rd & ~ddr_busy;
    assign wr_acc_c = ddr_we & ~ddr_busy;

    // Last beat of the current burst, in whichever phase it ends
    assign done_c = ((state == ST_CMD)   & ~rd_acc_c & wr_acc_c & (len_c == BW'(1)))
                  | ((state == ST_WDATA) & wr_acc_c & (cnt == BW'(1)))
                  | ((state == ST_RDATA) & ddr_dout_ready & (cnt == BW'(1)));

`ifdef JTFRAME_MR_DDRARB_RR_EN
    assign next_ptr_c = (idx == IW'(CH-1)) ? '0 : idx + IW'(1);
`endif

    assign m_busy       = {CH{ddr_busy | (state == ST_RDATA)}} | ~grant;
    assign m_dout_ready = {CH{ddr_dout_ready & (state == ST_RDATA)}} & grant;
    assign m_dout       = ddr_dout;
    assign ddr_clk      = clk;

    // Arbitration FSM with beat counter; grant is held for the whole burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            idx   <= '0;
            cnt   <= '0;
`ifdef JTFRAME_MR_DDRARB_RR_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any_c) begin
                        grant <= pick_oh_c;
                        idx   <= pick_idx_c;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rd_acc_c) begin
                        cnt   <= len_c;
                        state <= ST_RDATA;
                    end else if (wr_acc_c) begin
                        cnt   <= len_c - BW'(1);
                        state <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (wr_acc_c) cnt <= cnt - BW'(1);
                end
                ST_RDATA: begin
                    if (ddr_dout_ready) cnt <= cnt - BW'(1);
                end
                default: state <= ST_IDLE;
            endcase
            if (done_c) begin
                state <= ST_IDLE;
                grant <= '0;
`ifdef JTFRAME_MR_DDRARB_RR_EN
                ptr   <= next_ptr_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_jtframe_mr_ddrarb.sv
// Self-checking bench for jtframe_mr_ddrarb (CH=4); expectations follow
// JTFRAME_MR_DDRARB_RR_EN when defined, fixed priority otherwise.
module tb_jtframe_mr_ddrarb;

    localparam int unsigned CH  = 4;
    localparam int unsigned AW  = 29;
    localparam int unsigned DW  = 64;
    localparam int unsigned BW  = 8;
    localparam int unsigned BEW = DW / 8;
    localparam int          NCH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CH-1:0]       m_rd, m_we;
    logic [CH*AW-1:0]    m_addr;
    logic [CH*BW-1:0]    m_burstcnt;
    logic [CH*DW-1:0]    m_din;
    logic [CH*BEW-1:0]   m_be;
    logic [CH-1:0]       m_busy, m_dout_ready, grant;
    logic [DW-1:0]       m_dout;
    logic                ddr_clk, ddr_busy, ddr_rd, ddr_we;
    logic [AW-1:0]       ddr_addr;
    logic [BW-1:0]       ddr_burstcnt;
    logic [DW-1:0]       ddr_din, ddr_dout;
    logic [BEW-1:0]      ddr_be;
    logic                ddr_dout_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtframe_mr_ddrarb #(.CH(CH), .AW(AW), .DW(DW), .BW(BW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_rd           (m_rd),
        .m_we           (m_we),
        .m_addr         (m_addr),
        .m_burstcnt     (m_burstcnt),
        .m_din          (m_din),
        .m_be           (m_be),
        .m_busy         (m_busy),
        .m_dout_ready   (m_dout_ready),
        .m_dout         (m_dout),
        .grant          (grant),
        .ddr_clk        (ddr_clk),
        .ddr_busy       (ddr_busy),
        .ddr_rd         (ddr_rd),
        .ddr_we         (ddr_we),
        .ddr_addr       (ddr_addr),
        .ddr_burstcnt   (ddr_burstcnt),
        .ddr_din        (ddr_din),
        .ddr_be         (ddr_be),
        .ddr_dout       (ddr_dout),
        .ddr_dout_ready (ddr_dout_ready)
    );

    // Reference arbitration: scan from start p, first requester wins
    function automatic int model_pick(input logic [CH-1:0] req, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (req[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // Search start after a burst by channel w completes
    function automatic int model_next_ptr(input int w);
`ifdef JTFRAME_MR_DDRARB_RR_EN
        return (w + 1) % NCH;
`else
        return w - w;
`endif
    endfunction

    task automatic clear_inputs();
        m_rd = '0; m_we = '0; m_addr = '0; m_burstcnt = '0; m_din = '0; m_be = '0;
        ddr_busy = 1'b0; ddr_dout = '0; ddr_dout_ready = 1'b0;
    endtask

    task automatic set_master(input int i, input bit rd, input bit we, input logic [AW-1:0] a,
                              input logic [BW-1:0] b, input logic [DW-1:0] d, input logic [BEW-1:0] e);
        m_rd[i] = rd;
        m_we[i] = we;
        m_addr[i*AW +: AW] = a;
        m_burstcnt[i*BW +: BW] = b;
        m_din[i*DW +: DW] = d;
        m_be[i*BEW +: BEW] = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_rd = '1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        checks++;
        if ({ddr_rd, ddr_we} !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %b expected 00", {ddr_rd, ddr_we}); end
        checks++;
        if (m_busy !== '1) begin errors++; $display("FAIL reset_busy: got %b expected 1111", m_busy); end
        checks++;
        if (m_dout_ready !== '0) begin errors++; $display("FAIL reset_dready: got %b expected 0", m_dout_ready); end
        checks++;
        if (ddr_clk !== clk) begin errors++; $display("FAIL ddr_clk: got %b expected %b", ddr_clk, clk); end
        do_reset();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d;
        do_reset();
        @(negedge clk);
        set_master(1, 1'b1, 1'b0, AW'(32'h100), BW'(4), '0, '1);
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL rd_grant: got %b expected 0010", grant); end
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== AW'(32'h100) || ddr_burstcnt !== BW'(4))
            begin errors++; $display("FAIL rd_cmd: got rd=%b addr=%h bc=%0d expected rd=1 addr=100 bc=4", ddr_rd, ddr_addr, ddr_burstcnt); end
        checks++;
        if (m_busy !== 4'b1101) begin errors++; $display("FAIL rd_cmd_busy: got %b expected 1101", m_busy); end
        @(negedge clk);
        m_rd[1] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) begin
                #1;
                checks++;
                if (m_dout_ready !== '0 || m_busy[1] !== 1'b1 || ddr_rd !== 1'b0)
                    begin errors++; $display("FAIL rd_gap: got dready=%b busy1=%b rd=%b expected 0000 1 0", m_dout_ready, m_busy[1], ddr_rd); end
                @(negedge clk);
            end
            d = {$urandom, $urandom};
            ddr_dout = d;
            ddr_dout_ready = 1'b1;
            #1;
            checks++;
            if (m_dout_ready !== 4'b0010 || m_dout !== d)
                begin errors++; $display("FAIL rd_beat%0d: got dready=%b dout=%h expected 0010 %h", b, m_dout_ready, m_dout, d); end
            @(negedge clk);
            ddr_dout_ready = 1'b0;
        end
        ddr_dout_ready = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || m_dout_ready !== '0)
            begin errors++; $display("FAIL rd_end: got grant=%b dready=%b expected 0 0", grant, m_dout_ready); end
        @(negedge clk);
        ddr_dout_ready = 1'b0;
    endtask

    task automatic test_contention();
        logic [CH-1:0] exp2;
        do_reset();
        @(negedge clk);
        set_master(0, 1'b1, 1'b0, AW'(32'h1234), BW'(1), '0, '1);
        set_master(1, 1'b0, 1'b1, AW'(32'h5678), BW'(1), DW'(64'hAA55), '1);
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b0001 || m_busy[1] !== 1'b1 || ddr_rd !== 1'b1 || ddr_we !== 1'b0 || ddr_addr !== AW'(32'h1234))
            begin errors++; $display("FAIL cont_first: got grant=%b busy1=%b rd=%b we=%b addr=%h expected 0001 1 1 0 1234", grant, m_busy[1], ddr_rd, ddr_we, ddr_addr); end
        @(negedge clk);
        m_rd[0] = 1'b0;
        ddr_dout = DW'(64'h77);
        ddr_dout_ready = 1'b1;
        #1;
        checks++;
        if (m_dout_ready !== 4'b0001 || m_busy[1] !== 1'b1)
            begin errors++; $display("FAIL cont_data: got dready=%b busy1=%b expected 0001 1", m_dout_ready, m_busy[1]); end
        @(negedge clk);
        ddr_dout_ready = 1'b0;
        m_rd[0] = 1'b1;
        #1;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL cont_idle: got %b expected 0", grant); end
        @(negedge clk); #1;
`ifdef JTFRAME_MR_DDRARB_RR_EN
        exp2 = 4'b0010;
`else
        exp2 = 4'b0001;
`endif
        checks++;
        if (grant !== exp2) begin errors++; $display("FAIL cont_second: got %b expected %b", grant, exp2); end
    endtask

    task automatic test_write_stall();
        logic [DW-1:0] wd [8];
        int beat;
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        @(negedge clk);
        set_master(2, 1'b0, 1'b1, AW'(32'h2000), BW'(8), wd[0], 8'hF0);
        @(negedge clk);
        set_master(3, 1'b1, 1'b0, AW'(32'h3000), BW'(2), '0, '1);
        beat = 0;
        n = 0;
        while (beat < 8 && n < 200) begin
            ddr_busy = (n == 0) ? 1'b1 : 1'($urandom % 2);
            m_din[2*DW +: DW] = wd[beat];
            #1;
            checks++;
            if (grant !== 4'b0100 || ddr_we !== 1'b1 || ddr_din !== wd[beat] || m_busy[2] !== ddr_busy || m_busy[3] !== 1'b1)
                begin errors++; $display("FAIL wr_beat%0d: got grant=%b we=%b din=%h busy=%b expected 0100 1 %h busy2=%b", beat, grant, ddr_we, ddr_din, m_busy, wd[beat], ddr_busy); end
            if (!ddr_busy) beat++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (beat != 8) begin errors++; $display("FAIL wr_timeout: got %0d beats expected 8", beat); end
        m_we[2] = 1'b0;
        ddr_busy = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || ddr_we !== 1'b0) begin errors++; $display("FAIL wr_end: got grant=%b we=%b expected 0 0", grant, ddr_we); end
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b1000 || ddr_addr !== AW'(32'h3000))
            begin errors++; $display("FAIL wr_next: got grant=%b addr=%h expected 1000 3000", grant, ddr_addr); end
    endtask

    task automatic test_bcnt_zero();
        do_reset();
        @(negedge clk);
        set_master(1, 1'b0, 1'b1, AW'(32'h40), BW'(0), DW'(64'h1122), '1);
        @(negedge clk);
        ddr_busy = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0010 || ddr_we !== 1'b1 || ddr_burstcnt !== '0)
            begin errors++; $display("FAIL bc0_cmd: got grant=%b we=%b bc=%0d expected 0010 1 0", grant, ddr_we, ddr_burstcnt); end
        @(negedge clk);
        ddr_busy = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL bc0_stall: got %b expected 0010", grant); end
        @(negedge clk);
        m_we[1] = 1'b0;
        #1;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL bc0_done: got %b expected 0", grant); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        @(negedge clk);
        set_master(0, 1'b1, 1'b0, AW'(32'h80), BW'(4), '0, '1);
        @(negedge clk);
        @(negedge clk);
        m_rd[0] = 1'b0;
        ddr_dout_ready = 1'b1;
        @(negedge clk);
        ddr_dout_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || ddr_rd !== 1'b0 || m_busy !== '1)
            begin errors++; $display("FAIL mid_reset: got grant=%b rd=%b busy=%b expected 0 0 1111", grant, ddr_rd, m_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ddr_dout_ready = 1'b1;
            #1;
            checks++;
            if (m_dout_ready !== '0 || grant !== '0)
                begin errors++; $display("FAIL stray%0d: got dready=%b grant=%b expected 0 0", k, m_dout_ready, grant); end
            @(negedge clk);
        end
        ddr_dout_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int exp_seq [5];
        int p;
        do_reset();
        p = 0;
        for (int k = 0; k < 5; k++) begin
            exp_seq[k] = model_pick('1, p);
            p = model_next_ptr(exp_seq[k]);
        end
        @(negedge clk);
        for (int i = 0; i < NCH; i++) set_master(i, 1'b0, 1'b1, AW'(i), BW'(1), DW'(i), '1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if (grant !== (CH'(1) << exp_seq[k]))
                begin errors++; $display("FAIL fair%0d: got %b expected channel %0d", k, grant, exp_seq[k]); end
            @(negedge clk); #1;
            checks++;
            if (grant !== '0) begin errors++; $display("FAIL fair_gap%0d: got %b expected 0", k, grant); end
        end
    endtask

    task automatic test_random();
        bit              act  [NCH];
        bit              isrd [NCH];
        bit              racc [NCH];
        logic [AW-1:0]   ad   [NCH];
        logic [BW-1:0]   bc   [NCH];
        logic [DW-1:0]   d0   [NCH];
        logic [BEW-1:0]  be   [NCH];
        int              beat [NCH];
        logic [CH-1:0]   exp_g, req;
        int own, kind, left, ptr, len, ntx;
        bit fin;
        do_reset();
        for (int i = 0; i < NCH; i++) begin act[i] = 0; isrd[i] = 0; racc[i] = 0; beat[i] = 0; end
        own = -1; kind = 0; left = 0; ptr = 0; ntx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (!act[i] && ($urandom % 4 == 0)) begin
                    act[i] = 1; isrd[i] = 1'($urandom % 2); racc[i] = 0; beat[i] = 0;
                    ad[i] = AW'($urandom); bc[i] = BW'($urandom % 6);
                    d0[i] = {$urandom, $urandom}; be[i] = BEW'($urandom);
                end
                set_master(i, act[i] && isrd[i] && !racc[i], act[i] && !isrd[i], ad[i], bc[i],
                           d0[i] + DW'(beat[i]), be[i]);
            end
            ddr_busy = ($urandom % 3 == 0);
            ddr_dout_ready = (own >= 0 && kind == 2) ? 1'($urandom % 2) : ($urandom % 8 == 0);
            ddr_dout = {$urandom, $urandom};
            req = m_rd | m_we;
            #1;
            exp_g = (own < 0) ? '0 : (CH'(1) << own);
            fin = 0;
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL rnd_grant cyc%0d: got %b expected %b", cyc, grant, exp_g); end
            if (own < 0) begin
                checks++;
                if ({ddr_rd, ddr_we} !== 2'b00 || m_busy !== '1 || m_dout_ready !== '0)
                    begin errors++; $display("FAIL rnd_idle cyc%0d: got rd=%b we=%b busy=%b dready=%b", cyc, ddr_rd, ddr_we, m_busy, m_dout_ready); end
                if (req != '0) begin own = model_pick(req, ptr); kind = 0; end
            end else begin
                len = (bc[own] == '0) ? 1 : int'(bc[own]);
                if (kind == 2) begin
                    checks++;
                    if ({ddr_rd, ddr_we} !== 2'b00 || m_busy !== '1 || m_dout_ready !== (ddr_dout_ready ? exp_g : '0) || m_dout !== ddr_dout)
                        begin errors++; $display("FAIL rnd_rdata cyc%0d: got rd=%b we=%b busy=%b dready=%b", cyc, ddr_rd, ddr_we, m_busy, m_dout_ready); end
                    if (ddr_dout_ready) begin left--; fin = (left == 0); end
                end else begin
                    checks++;
                    if (ddr_rd !== (kind == 0 && isrd[own]) || ddr_we !== !isrd[own] || ddr_addr !== ad[own] ||
                        ddr_burstcnt !== bc[own] || m_busy !== (ddr_busy ? '1 : ~exp_g) || m_dout_ready !== '0)
                        begin errors++; $display("FAIL rnd_cmd cyc%0d ch%0d: got rd=%b we=%b addr=%h bc=%0d busy=%b expected addr=%h bc=%0d", cyc, own, ddr_rd, ddr_we, ddr_addr, ddr_burstcnt, m_busy, ad[own], bc[own]); end
                    if (!isrd[own]) begin
                        checks++;
                        if (ddr_din !== d0[own] + DW'(beat[own]) || ddr_be !== be[own])
                            begin errors++; $display("FAIL rnd_wdata cyc%0d: got %h/%h expected %h/%h", cyc, ddr_din, ddr_be, d0[own] + DW'(beat[own]), be[own]); end
                    end
                    if (!ddr_busy) begin
                        if (isrd[own]) begin
                            racc[own] = 1; kind = 2; left = len;
                        end else begin
                            beat[own]++;
                            if (kind == 0) left = len;
                            left--;
                            kind = 1;
                            fin = (left == 0);
                        end
                    end
                end
                if (fin) begin
                    ptr = model_next_ptr(own);
                    act[own] = 0;
                    own = -1;
                    ntx++;
                end
            end
        end
        checks++;
        if (ntx < 100) begin errors++; $display("FAIL rnd_progress: got %0d bursts expected at least 100", ntx); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_stall();
        test_bcnt_zero();
        test_reset_midburst();
        test_fairness();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
